riscv_dmem_responder: RTL and testbench

RISCV_DMEM_RESPONDER -- requirements
Module: riscv_dmem_responder

---
 rtl/riscv_dmem_responder.sv | 159 +++++++++++++++
 tb/tb_riscv_dmem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_responder.sv
// Big-endian byte-addressed data memory responder with a fixed request-to-response latency.
// Optional macro RISCV_DMEM_ALIGN_CHECK_EN: misaligned halfword/word accesses report an error instead of being aligned.
module riscv_dmem_responder #(
  parameter int DEPTH_BYTES = 4096,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  // state | meaning
  // IDLE  | ready to accept a request
  // WAIT  | latency countdown, access not yet performed
  // RESP  | response presented until rsp_ready
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam logic [3:0]  CNT_INIT  = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [32:0] DEPTH_EXT = 33'(DEPTH_BYTES);

  state_t state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        enter_resp, commit, accept;
  logic        cap_we;
  logic [1:0]  cap_size;
  logic [31:0] cap_addr, cap_wdata;
  logic        op_we;
  logic [1:0]  op_size;
  logic [31:0] op_addr, op_wdata, eff_addr, rd_word;
  logic [32:0] span, last_addr;
  logic        misalign, op_err;
  logic [AW-1:0] i0, i1, i2, i3;
  logic [7:0]  mem [DEPTH_BYTES];

  assign req_ready = (state == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == RESP);
  assign commit    = enter_resp && rst_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap_we    <= req_we;
        cap_size  <= req_size;
        cap_addr  <= req_addr;
        cap_wdata <= req_wdata;
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: if (accept) begin
        if (LATENCY == 1) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_INIT;
        end
      end
      WAIT: if (cnt == 4'd0) begin
        state_nxt  = RESP;
        enter_resp = 1'b1;
      end else begin
        cnt_nxt = cnt - 4'd1;
      end
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY = 1 the access happens on the acceptance edge, so use the live request.
  always_comb begin
    op_we    = (state == IDLE) ? req_we    : cap_we;
    op_size  = (state == IDLE) ? req_size  : cap_size;
    op_addr  = (state == IDLE) ? req_addr  : cap_addr;
    op_wdata = (state == IDLE) ? req_wdata : cap_wdata;
  end

  always_comb begin
    eff_addr = op_addr;
    misalign = 1'b0;
`ifdef RISCV_DMEM_ALIGN_CHECK_EN
    misalign = ((op_size == 2'b01) && op_addr[0]) ||
               ((op_size == 2'b10) && (op_addr[1:0] != 2'b00));
`else
    if (op_size == 2'b01) eff_addr = {op_addr[31:1], 1'b0};
    if (op_size == 2'b10) eff_addr = {op_addr[31:2], 2'b00};
`endif
    case (op_size)
      2'b01:   span = 33'd1;
      2'b10:   span = 33'd3;
      default: span = 33'd0;
    endcase
    last_addr = {1'b0, eff_addr} + span;
    op_err    = (op_size == 2'b11) || misalign || (last_addr >= DEPTH_EXT);
    i0 = eff_addr[AW-1:0];
    i1 = i0 + AW'(1);
    i2 = i0 + AW'(2);
    i3 = i0 + AW'(3);
    case (op_size)
      2'b00:   rd_word = {24'd0, mem[i0]};
      2'b01:   rd_word = {16'd0, mem[i0], mem[i1]};
      2'b10:   rd_word = {mem[i0], mem[i1], mem[i2], mem[i3]};
      default: rd_word = 32'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else if (commit) begin
      rsp_err   <= op_err;
      rsp_rdata <= (op_we || op_err) ? 32'd0 : rd_word;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end
  end

  // Memory is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (commit && op_we && !op_err) begin
      case (op_size)
        2'b00: mem[i0] <= op_wdata[7:0];
        2'b01: begin
          mem[i0] <= op_wdata[15:8];
          mem[i1] <= op_wdata[7:0];
        end
        2'b10: begin
          mem[i0] <= op_wdata[31:24];
          mem[i1] <= op_wdata[23:16];
          mem[i2] <= op_wdata[15:8];
          mem[i3] <= op_wdata[7:0];
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_dmem_responder.sv
// Bench for riscv_dmem_responder: transaction-level memory model checked every cycle plus literal expectations.
module tb_riscv_dmem_responder;
  localparam int DEPTH = 4096;
  localparam int LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  int checks = 0;
  int errors = 0;

  riscv_dmem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Transaction model: bytes addressed big-endian, access resolved on its due edge.
  logic [7:0]  model_mem [DEPTH];
  int          cyc = 0;
  int          due = 0;
  bit          busy = 0;
  bit          chk_en = 0;
  logic        m_we;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, exp_rdata;
  logic        exp_err;

  task automatic model_access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic err, output logic [31:0] rdata);
    int n;
    longint a;
    bit mis;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
    a = longint'(addr);
    mis = 0;
`ifdef RISCV_DMEM_ALIGN_CHECK_EN
    if (n > 1 && (a % n) != 0) mis = 1;
`else
    if (n > 1) a = a - (a % n);
`endif
    err = (n == 0) || mis || (a + n - 1 >= DEPTH);
    rdata = 32'd0;
    if (!err)
      for (int k = 0; k < n; k++) begin
        if (we) model_mem[int'(a) + k] = 8'(wdata >> (8 * (n - 1 - k)));
        else    rdata = (rdata << 8) | 32'(model_mem[int'(a) + k]);
      end
  endtask

  always @(posedge clk) begin
    int e;
    e = cyc + 1;
    if (!rst_n) begin
      busy   = 0;
      chk_en = 1;
    end else if (busy && cyc >= due && rsp_ready) begin
      busy = 0;
    end else if (busy && e == due) begin
      model_access(m_we, m_size, m_addr, m_wdata, exp_err, exp_rdata);
    end else if (!busy && req_valid) begin
      busy = 1;
      m_we = req_we; m_size = req_size; m_addr = req_addr; m_wdata = req_wdata;
      due = e + LAT - 1;
      if (e == due) model_access(m_we, m_size, m_addr, m_wdata, exp_err, exp_rdata);
    end
    cyc = e;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      bit ev;
      ev = busy && (cyc >= due);
      chk("req_ready", 32'(req_ready), 32'(rst_n && !busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("rsp_rdata", rsp_rdata, ev ? exp_rdata : 32'd0);
      chk("rsp_err",   32'(rsp_err), ev ? 32'(exp_err) : 32'd0);
    end
  end

  task automatic run_req(input string name, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                         output logic [31:0] rd, output logic er, output int lat);
    int acc;
    bit got;
    rd = 32'd0; er = 1'b0; lat = -1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    if (!got) begin
      chk({name, "_accept_timeout"}, 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    acc = cyc;
    req_valid = 1'b0; req_we = ~we; req_addr = ~addr; req_wdata = ~wdata;
    got = 0;
    for (int t = 0; t < 40 && !got; t++) begin
      @(negedge clk);
      if (rsp_valid) got = 1;
    end
    if (!got) begin
      chk({name, "_rsp_timeout"}, 32'(rsp_valid), 32'd1);
      return;
    end
    lat = cyc - acc + 1;
    rd = rsp_rdata;
    er = rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({name, "_hold_valid"}, 32'(rsp_valid), 32'd1);
      chk({name, "_hold_req_ready"}, 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic er;
    int lat;
    bit got;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 32'(req_ready), 32'd0);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_req_ready", 32'(req_ready), 32'd1);

    run_req("st_w_010", 1'b1, 2'd2, 32'h010, 32'hDEADBEEF, 0, rd, er, lat);
    chk("st_w_010_lat", 32'(lat), 32'd2);
    chk("st_w_010_err", 32'(er), 32'd0);
    chk("st_w_010_rd", rd, 32'd0);
    run_req("ld_w_010", 1'b0, 2'd2, 32'h010, 32'h0, 0, rd, er, lat);
    chk("ld_w_010_lat", 32'(lat), 32'd2);
    chk("ld_w_010_rd", rd, 32'hDEADBEEF);
    chk("ld_w_010_err", 32'(er), 32'd0);
    run_req("ld_b_011", 1'b0, 2'd0, 32'h011, 32'h0, 0, rd, er, lat);
    chk("ld_b_011_rd", rd, 32'h000000AD);
    run_req("ld_b_013", 1'b0, 2'd0, 32'h013, 32'h0, 0, rd, er, lat);
    chk("ld_b_013_rd", rd, 32'h000000EF);
    run_req("ld_h_012", 1'b0, 2'd1, 32'h012, 32'h0, 0, rd, er, lat);
    chk("ld_h_012_rd", rd, 32'h0000BEEF);
    run_req("ld_w_hold", 1'b0, 2'd2, 32'h010, 32'h0, 5, rd, er, lat);
    chk("ld_w_hold_rd", rd, 32'hDEADBEEF);

    run_req("ld_w_012", 1'b0, 2'd2, 32'h012, 32'h0, 0, rd, er, lat);
`ifdef RISCV_DMEM_ALIGN_CHECK_EN
    chk("ld_w_012_err", 32'(er), 32'd1);
    chk("ld_w_012_rd", rd, 32'd0);
`else
    chk("ld_w_012_err", 32'(er), 32'd0);
    chk("ld_w_012_rd", rd, 32'hDEADBEEF);
`endif

    run_req("st_b_ffe", 1'b1, 2'd0, 32'hFFE, 32'h000000A5, 0, rd, er, lat);
    run_req("st_b_fff", 1'b1, 2'd0, 32'hFFF, 32'h0000005A, 0, rd, er, lat);
    chk("st_b_fff_err", 32'(er), 32'd0);
    run_req("st_w_ffe", 1'b1, 2'd2, 32'hFFE, 32'h00000055, 0, rd, er, lat);
    run_req("ld_h_ffe", 1'b0, 2'd1, 32'hFFE, 32'h0, 0, rd, er, lat);
`ifdef RISCV_DMEM_ALIGN_CHECK_EN
    chk("ld_h_ffe_rd", rd, 32'h0000A55A);
`else
    chk("ld_h_ffe_rd", rd, 32'h00000055);
`endif
    run_req("st_w_1000", 1'b1, 2'd2, 32'h1000, 32'h00000055, 0, rd, er, lat);
    chk("st_w_1000_err", 32'(er), 32'd1);
    run_req("ld_b_1000", 1'b0, 2'd0, 32'h1000, 32'h0, 0, rd, er, lat);
    chk("ld_b_1000_err", 32'(er), 32'd1);
    chk("ld_b_1000_rd", rd, 32'd0);
    run_req("ld_size3", 1'b0, 2'd3, 32'h010, 32'h0, 0, rd, er, lat);
    chk("ld_size3_err", 32'(er), 32'd1);
    chk("ld_size3_rd", rd, 32'd0);

    run_req("st_w_020", 1'b1, 2'd2, 32'h020, 32'h11223344, 0, rd, er, lat);
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h020; req_wdata = 32'hCAFEF00D;
    got = 0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (req_ready) got = 1;
    end
    chk("rst_wait_accept", 32'(got), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      chk("rst_wait_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_req("ld_w_020", 1'b0, 2'd2, 32'h020, 32'h0, 0, rd, er, lat);
    chk("ld_w_020_rd", rd, 32'h11223344);

    run_req("st_w_014", 1'b1, 2'd2, 32'h014, 32'h01020304, 0, rd, er, lat);
    run_req("st_h_016", 1'b1, 2'd1, 32'h016, 32'hFFFFABCD, 0, rd, er, lat);
    run_req("st_b_015", 1'b1, 2'd0, 32'h015, 32'hFFFFFF77, 0, rd, er, lat);
    run_req("ld_w_014", 1'b0, 2'd2, 32'h014, 32'h0, 0, rd, er, lat);
    chk("ld_w_014_rd", rd, 32'h0177ABCD);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
